// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset release controller.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } seq_state_t;

  localparam int STATE_W = 2;

  // Counter must hold the largest terminal count without wrapping.
  function automatic int cnt_width(input int stretch_cycles, input int stage_gap);
    int max_v;
    max_v = (stretch_cycles > stage_gap) ? stretch_cycles : stage_gap;
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Status/control bundle between the reset sequencer and its environment.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import reset_sequencer_pkg::*;

  logic                  pll_locked;
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] rst_n_out;
  logic                  seq_done;
  logic [STATE_W-1:0]    seq_state;

  modport master (
    output pll_locked, sw_rst_req,
    input  rst_n_out, seq_done, seq_state
  );

  modport slave (
    input  pll_locked, sw_rst_req,
    output rst_n_out, seq_done, seq_state
  );

endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Multi-flop synchronizer for a level signal crossing into the clk domain.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= '0;
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Waits for PLL lock, stretches reset, then releases per-stage active-low
// resets one at a time; lock loss or a software request restarts everything.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8,
  parameter int SYNC_STAGES    = 2
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.slave  bus
);

  localparam int CNT_W = cnt_width(STRETCH_CYCLES, STAGE_GAP);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0]      STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] STAGE0       = NUM_STAGES'(1);

  logic                  locked_sync;
  seq_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] rst_n_q;
  logic                  done_q;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_sync)
  );

  // Stages release in index order, so each release shifts one more 1 in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else if (!locked_sync || bus.sw_rst_req) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state <= STRETCH;
          cnt   <= '0;
        end
        STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            rst_n_q <= STAGE0;
            cnt     <= '0;
            idx     <= '0;
            if (NUM_STAGES == 1) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_n_q <= (rst_n_q << 1) | STAGE0;
            cnt     <= '0;
            idx     <= idx + 1'b1;
            if (int'(idx) == NUM_STAGES - 2) begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    ;
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 3-stage instance plus a
// single-stage, minimum-timing instance sharing clock, reset and inputs.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(3)) bus ();
  reset_sequencer_if #(.NUM_STAGES(1)) bus1 ();

  assign bus1.pll_locked = bus.pll_locked;
  assign bus1.sw_rst_req = bus.sw_rst_req;

  reset_sequencer #(
    .NUM_STAGES(3), .STRETCH_CYCLES(16), .STAGE_GAP(8), .SYNC_STAGES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .STRETCH_CYCLES(1), .STAGE_GAP(1), .SYNC_STAGES(2)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Advance to 1 time unit after edge k (edges counted from rst release).
  task automatic step_to(input int k);
    while (edge_cnt < k) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
  endtask

  task automatic check3(input string tag, input logic [2:0] out, input logic done,
                        input logic [1:0] st);
    check({tag, ".out"},   {5'd0, bus.rst_n_out}, {5'd0, out});
    check({tag, ".done"},  {7'd0, bus.seq_done},  {7'd0, done});
    check({tag, ".state"}, {6'd0, bus.seq_state}, {6'd0, st});
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst      = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.sw_rst_req = 1'b0;
    #2;
    check3("reset", 3'b000, 1'b0, 2'd0);
    check("reset1.out", {7'd0, bus1.rst_n_out}, 8'd0);

    // pll_locked never rises: outputs stay in reset
    release_rst();
    for (int i = 1; i <= 100; i++) begin
      step_to(i);
      check("nolock.out",   {5'd0, bus.rst_n_out}, 8'd0);
      check("nolock.state", {6'd0, bus.seq_state}, 8'd0);
    end

    // Fresh reset, lock before edge 5: E=7, releases at 23/31/39
    @(negedge clk);
    rst = 1'b0;
    #1;
    check3("rst2", 3'b000, 1'b0, 2'd0);
    release_rst();
    step_to(4);
    bus.pll_locked = 1'b1;
    step_to(6);  check3("e6",  3'b000, 1'b0, 2'd0);
    step_to(7);  check3("e7",  3'b000, 1'b0, 2'd1);
    check("m1.e7.out",  {7'd0, bus1.rst_n_out}, 8'd0);
    check("m1.e7.state", {6'd0, bus1.seq_state}, 8'd1);
    step_to(8);
    check("m1.e8.out",  {7'd0, bus1.rst_n_out}, 8'd1);
    check("m1.e8.done", {7'd0, bus1.seq_done},  8'd1);
    check("m1.e8.state", {6'd0, bus1.seq_state}, 8'd3);
    step_to(22); check3("e22", 3'b000, 1'b0, 2'd1);
    step_to(23); check3("e23", 3'b001, 1'b0, 2'd2);
    step_to(30); check3("e30", 3'b001, 1'b0, 2'd2);
    step_to(31); check3("e31", 3'b011, 1'b0, 2'd2);
    step_to(38); check3("e38", 3'b011, 1'b0, 2'd2);
    step_to(39); check3("e39", 3'b111, 1'b1, 2'd3);

    // Lock loss before edge F=45: outputs drop after edge 47
    step_to(44);
    bus.pll_locked = 1'b0;
    step_to(46); check3("f46", 3'b111, 1'b1, 2'd3);
    step_to(47); check3("f47", 3'b000, 1'b0, 2'd0);
    check("m1.f47.out", {7'd0, bus1.rst_n_out}, 8'd0);

    // Relock before edge 50: E=52, releases at 68/76/84
    step_to(49);
    bus.pll_locked = 1'b1;
    step_to(52); check3("r52", 3'b000, 1'b0, 2'd1);
    step_to(67); check3("r67", 3'b000, 1'b0, 2'd1);
    step_to(68); check3("r68", 3'b001, 1'b0, 2'd2);
    step_to(76); check3("r76", 3'b011, 1'b0, 2'd2);
    step_to(84); check3("r84", 3'b111, 1'b1, 2'd3);

    // Software request in DONE at edge 86: restart with E=87
    step_to(85);
    bus.sw_rst_req = 1'b1;
    step_to(86);
    bus.sw_rst_req = 1'b0;
    check3("s86", 3'b000, 1'b0, 2'd0);
    step_to(87);  check3("s87",  3'b000, 1'b0, 2'd1);
    step_to(103); check3("s103", 3'b001, 1'b0, 2'd2);

    // Software request on the stage-1 release edge 111: abort wins
    step_to(110);
    check3("s110", 3'b001, 1'b0, 2'd2);
    bus.sw_rst_req = 1'b1;
    step_to(111);
    bus.sw_rst_req = 1'b0;
    check3("s111", 3'b000, 1'b0, 2'd0);
    step_to(112); check3("s112", 3'b000, 1'b0, 2'd1);
    step_to(127); check3("s127", 3'b000, 1'b0, 2'd1);
    step_to(128); check3("s128", 3'b001, 1'b0, 2'd2);
    step_to(136); check3("s136", 3'b011, 1'b0, 2'd2);

    // Async reset mid-RELEASE, away from any clock edge
    step_to(140);
    check3("a140", 3'b011, 1'b0, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    check3("async", 3'b000, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    check3("async_hold", 3'b000, 1'b0, 2'd0);
    // Lock already high: captured at edge 1, so E=3
    release_rst();
    step_to(2);  check3("p2",  3'b000, 1'b0, 2'd0);
    step_to(3);  check3("p3",  3'b000, 1'b0, 2'd1);
    step_to(18); check3("p18", 3'b000, 1'b0, 2'd1);
    step_to(19); check3("p19", 3'b001, 1'b0, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset release controller for the clock domain fed by the reset synchronizer. Takes the already-synchronized domain reset, waits for PLL lock, stretches the reset for a fixed number of cycles, then deasserts a vector of active-low sub-block resets one at a time with a fixed gap. Loss of lock or a software reset request re-asserts all outputs and restarts the sequence.

## Interface
- NUM_STAGES, 3, number of sequenced reset outputs (1..8)
- STRETCH_CYCLES, 16, cycles between lock detection and stage 0 release (>=1)
- STAGE_GAP, 8, cycles between consecutive stage releases (>=1)
- SYNC_STAGES, 2, flop depth of the pll_locked synchronizer (>=2)

- clk  input  1  domain clock
- rst  input  1  reset, asynchronous, active-low; synchronously deasserted upstream
- pll_locked  input  1  PLL lock, asynchronous to clk
- sw_rst_req  input  1  synchronous software reset request, sampled every edge
- rst_n_out  output  NUM_STAGES  per-stage reset, active-low, registered
- seq_done  output  1  high when every stage released
- seq_state  output  2  current FSM state encoding, for debug/status

## Operation
- States: WAIT_LOCK(0), STRETCH(1), RELEASE(2), DONE(3).
- rst low: immediately (async) state=WAIT_LOCK, rst_n_out=0, seq_done=0, counter=0, stage index=0, synchronizer flops=0.
- WAIT_LOCK: holds outputs 0; on locked_sync=1 -> STRETCH, counter=0.
- STRETCH: counter increments; after STRETCH_CYCLES cycles in STRETCH, rst_n_out[0]<=1, -> RELEASE (counter=0, idx=0); if NUM_STAGES=1 go directly to DONE with seq_done<=1.
- RELEASE: counter increments; after STAGE_GAP cycles, rst_n_out[idx+1]<=1, idx++, counter=0; the edge releasing rst_n_out[NUM_STAGES-1] also sets seq_done<=1 and -> DONE.
- DONE: holds all outputs 1.
- Abort (any state except reset): locked_sync=0 or sw_rst_req=1 -> on that edge rst_n_out<=0, seq_done<=0, counter=0, idx=0, -> WAIT_LOCK. Abort in WAIT_LOCK keeps it there and clears counter.
- Priority: rst > abort > normal progression. Abort on the same edge as a scheduled release: abort wins, no release.
- Released stages never re-assert individually; re-assertion is always all-stages together.
- Counter width = clog2(max(STRETCH_CYCLES, STAGE_GAP)+1); never wraps (cleared on every transition).

## Timing
- pll_locked rising before edge P: locked_sync=1 after edge P+SYNC_STAGES-1; FSM samples it at edge E=P+SYNC_STAGES.
- rst_n_out[k] rises at edge E+STRETCH_CYCLES+k*STAGE_GAP; seq_done rises with rst_n_out[NUM_STAGES-1].
- pll_locked falling before edge F: all outputs 0 after edge F+SYNC_STAGES.
- sw_rst_req high at edge S: all outputs 0 after edge S; if lock held, restart: E=S+1.
- Glitch on pll_locked shorter than one clk period may or may not be captured; if captured, it aborts.
- All outputs glitch-free flop outputs; no combinational path from inputs to outputs.

## Structure
- Shared package: state enum (WAIT_LOCK/STRETCH/RELEASE/DONE), state width constant, clog2 counter-width function.
- One sub-module: sync_2ff (parameterised depth SYNC_STAGES, async active-low reset to 0) for pll_locked.
- Top: FSM, counter, stage index, output register vector.

## Test plan
- Defaults, rst released, pll_locked high before edge P=5 -> rst_n_out=3'b001 at edge 23, 3'b011 at 31, 3'b111 and seq_done=1 at 39.
- pll_locked held low 100 cycles after rst release -> rst_n_out=0, seq_state=0 throughout.
- In DONE, pll_locked low before edge F -> rst_n_out=0, seq_done=0 after edge F+2; relock repeats full sequence with identical spacing.
- sw_rst_req one-cycle pulse at exactly the edge scheduled for stage 1 release -> stage 1 not released, all outputs 0, sequence restarts with E=S+1.
- rst asserted mid-RELEASE (rst_n_out=3'b011) -> outputs 0 immediately without clock edge, state WAIT_LOCK; synchronizer cleared so E is again P+2 relative to post-release lock.
- NUM_STAGES=1, STRETCH_CYCLES=1, STAGE_GAP=1 -> rst_n_out[0] and seq_done rise at edge E+1.
